// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: serialises host words onto a configuration shift chain using a
// self-generated chain clock, and collects the bits leaving the chain tail as readback words.

module cfg_chain_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              start,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ccff_head,
   output logic              ccff_clk,
   input  logic              ccff_tail,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              cfg_done
);

   localparam int BW = $clog2(CHAIN_LEN + 1);
   localparam int IW = $clog2(WORD_W + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      SETUP = 3'd2,
      PULSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic [WORD_W-1:0] word_q, word_nxt;
   logic [WORD_W-1:0] rb_q, rb_nxt, rb_with_tail;
   logic [WORD_W-1:0] rd_data_nxt;
   logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
   logic [IW-1:0]     idx, idx_nxt;
   logic              head_nxt, rd_valid_nxt, last_in_group;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // Host port: a word transfers on a clock edge where in_valid and in_ready are both
   // high. in_ready is raised only in FETCH; in_valid is ignored in every other state.
   always_comb begin
      state_nxt     = state;
      word_nxt      = word_q;
      idx_nxt       = idx;
      bit_cnt_nxt   = bit_cnt;
      rb_nxt        = rb_q;
      rd_data_nxt   = rd_data;
      rd_valid_nxt  = 1'b0;
      head_nxt      = ccff_head;
      rb_with_tail  = rb_q | (WORD_W'(ccff_tail) << idx);
      last_in_group = (idx == IW'(WORD_W - 1)) || (bit_cnt == BW'(CHAIN_LEN - 1));
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt   = FETCH;
               bit_cnt_nxt = '0;
               idx_nxt     = '0;
               rb_nxt      = '0;
            end
         end
         FETCH: begin
            if (in_valid && in_ready) begin
               word_nxt  = in_data;
               idx_nxt   = '0;
               head_nxt  = in_data[0];
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            // The tail bit is sampled before the pulse, so it is the chain's old content.
            if (last_in_group) begin
               rd_data_nxt  = rb_with_tail;
               rd_valid_nxt = 1'b1;
               rb_nxt       = '0;
            end else begin
               rb_nxt = rb_with_tail;
            end
            state_nxt = PULSE;
         end
         PULSE: begin
            bit_cnt_nxt = bit_cnt + BW'(1);
            idx_nxt     = idx + IW'(1);
            if (bit_cnt_nxt == BW'(CHAIN_LEN)) begin
               state_nxt = DONE;
            end else if (idx_nxt == IW'(WORD_W)) begin
               state_nxt = FETCH;
            end else begin
               state_nxt = SETUP;
               head_nxt  = |(word_q & (WORD_W'(1) << idx_nxt));
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so each one is glitch-free at the pins.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         word_q    <= '0;
         rb_q      <= '0;
         bit_cnt   <= '0;
         idx       <= '0;
         in_ready  <= 1'b0;
         ccff_head <= 1'b0;
         ccff_clk  <= 1'b0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         busy      <= 1'b0;
         cfg_done  <= 1'b0;
      end else begin
         word_q    <= word_nxt;
         rb_q      <= rb_nxt;
         bit_cnt   <= bit_cnt_nxt;
         idx       <= idx_nxt;
         ccff_head <= head_nxt;
         rd_data   <= rd_data_nxt;
         rd_valid  <= rd_valid_nxt;
         in_ready  <= (state_nxt == FETCH);
         ccff_clk  <= (state_nxt == PULSE);
         busy      <= (state_nxt == FETCH) || (state_nxt == SETUP) || (state_nxt == PULSE);
         cfg_done  <= (state_nxt == DONE);
      end
   end

endmodule
